// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Brief    : Pipeline <-> hazard controller signal bundle. The pipeline side
//             (master) drives operand/opcode/memory status and receives the
//             stall, flush, error and counter outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           rs1_addr_id;
  logic [4:0]           rs2_addr_id;
  logic [6:0]           opcode_id;
  logic [4:0]           rd_addr_ex;
  logic                 ctrl_mem_read_ex;
  logic                 redirect_ex;
  logic                 dmem_req_mem;
  logic                 dmem_ready;

  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 id_ex_stall;
  logic                 ex_mem_stall;
  logic                 if_id_flush;
  logic                 id_ex_flush;
  logic                 mem_timeout_err;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;
  logic [1:0]           state;

  modport master (
    output rs1_addr_id, rs2_addr_id, opcode_id, rd_addr_ex,
           ctrl_mem_read_ex, redirect_ex, dmem_req_mem, dmem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_timeout_err,
           stall_cycles, flush_count, state
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, opcode_id, rd_addr_ex,
           ctrl_mem_read_ex, redirect_ex, dmem_req_mem, dmem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_timeout_err,
           stall_cycles, flush_count, state
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Five-stage pipeline hazard controller. Resolves data-memory
//             waits, EX redirects and load-use hazards into stall/flush
//             controls; tracks memory timeouts and stall/flush statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int         c_wait_w    = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_BUBBLE = 2'd1,
    MEM_WAIT    = 2'd2,
    ILLEGAL     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_wait_w-1:0]   r_wait_cnt;
  logic [c_wait_w-1:0]   w_wait_cnt_nxt;
  logic                  r_timeout_err;
  logic [CNT_WIDTH-1:0]  r_stall_cycles;
  logic [CNT_WIDTH-1:0]  r_flush_count;

  logic w_rs1_used;
  logic w_rs2_used;
  logic w_load_use;
  logic w_mem_wait;
  logic w_wait_cycle;
  logic w_pc_stall;
  logic w_if_id_stall;
  logic w_id_ex_stall;
  logic w_ex_mem_stall;
  logic w_if_id_flush;
  logic w_id_ex_flush;

  // Operand usage by opcode: rs1 is unused only by LUI/AUIPC/JAL, rs2 only
  // matters for register-register ALU ops, stores and branches.
  assign w_rs1_used = !((hz.opcode_id == c_op_lui) || (hz.opcode_id == c_op_auipc) ||
                        (hz.opcode_id == c_op_jal));
  assign w_rs2_used = (hz.opcode_id == c_op_rtype) || (hz.opcode_id == c_op_store) ||
                      (hz.opcode_id == c_op_branch);

  assign w_load_use = hz.ctrl_mem_read_ex && (hz.rd_addr_ex != 5'd0) &&
                      (((hz.rs1_addr_id == hz.rd_addr_ex) && w_rs1_used) ||
                       ((hz.rs2_addr_id == hz.rd_addr_ex) && w_rs2_used));

  assign w_mem_wait = hz.dmem_req_mem && !hz.dmem_ready;

  // State register; reset discards any pending bubble or memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and stall/flush decode, priority memory wait > redirect > load-use.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cycle   = 1'b0;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_wait) begin
          w_wait_cycle   = 1'b1;
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          w_state_nxt    = MEM_WAIT;
        end else if (hz.redirect_ex) begin
          w_if_id_flush  = 1'b1;
          w_id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_flush  = 1'b1;
          w_state_nxt    = LOAD_BUBBLE;
        end
      end
      LOAD_BUBBLE: begin
        w_state_nxt = RUN;
        if (w_mem_wait) begin
          w_wait_cycle   = 1'b1;
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
          w_state_nxt    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_ready) begin
          w_wait_cycle   = 1'b1;
          w_pc_stall     = 1'b1;
          w_if_id_stall  = 1'b1;
          w_id_ex_stall  = 1'b1;
          w_ex_mem_stall = 1'b1;
        end else begin
          w_state_nxt    = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // The cycle that first detects the wait counts as a wait cycle, so the
  // counter equals the number of stalled memory cycles so far. It holds at
  // MEM_TIMEOUT rather than wrapping.
  assign w_wait_cnt_nxt = (r_wait_cnt == c_wait_w'(MEM_TIMEOUT)) ? r_wait_cnt
                                                                 : r_wait_cnt + 1'b1;

  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_wait_cycle) begin
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_wait_cnt_nxt == c_wait_w'(MEM_TIMEOUT)) begin
        r_timeout_err <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_pc_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_id_ex_flush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  // Controls are gated by rst_n so an asserted reset drops them at once.
  assign hz.pc_stall        = rst_n && w_pc_stall;
  assign hz.if_id_stall     = rst_n && w_if_id_stall;
  assign hz.id_ex_stall     = rst_n && w_id_ex_stall;
  assign hz.ex_mem_stall    = rst_n && w_ex_mem_stall;
  assign hz.if_id_flush     = rst_n && w_if_id_flush;
  assign hz.id_ex_flush     = rst_n && w_id_ex_flush;
  assign hz.mem_timeout_err = r_timeout_err;
  assign hz.stall_cycles    = r_stall_cycles;
  assign hz.flush_count     = r_flush_count;
  assign hz.state           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Directed, table-driven self-checking bench for hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_WIDTH   = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_stall;
  int   exp_flush;

  hazard_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] op;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       req;
    logic       rdy;
    logic [5:0] exp_o;   // {pc, if_id, id_ex, ex_mem stall, if_id, id_ex flush}
    logic [1:0] exp_st;  // state after the edge
  } vec_t;

  vec_t tbl[$];

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  task automatic add(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [6:0] op, input logic [4:0] rd, input logic ld,
                     input logic redir, input logic req, input logic rdy,
                     input logic [5:0] exp_o, input logic [1:0] exp_st);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.op = op; v.rd = rd; v.ld = ld;
    v.redir = redir; v.req = req; v.rdy = rdy; v.exp_o = exp_o; v.exp_st = exp_st;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] op,
                       input logic [4:0] rd, input logic ld, input logic redir,
                       input logic req, input logic rdy);
    bus.rs1_addr_id      = rs1;
    bus.rs2_addr_id      = rs2;
    bus.opcode_id        = op;
    bus.rd_addr_ex       = rd;
    bus.ctrl_mem_read_ex = ld;
    bus.redirect_ex      = redir;
    bus.dmem_req_mem     = req;
    bus.dmem_ready       = rdy;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, OP_I, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.pc_stall, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
            bus.if_id_flush, bus.id_ex_flush};
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle output check, then clock, then state check.
  task automatic cycle(input string name, input logic [5:0] exp_o, input logic [1:0] exp_st);
    #3;
    check({name, "_outs"}, 64'(outs()), 64'(exp_o));
    exp_stall += int'(exp_o[5]);
    exp_flush += int'(exp_o[0]);
    tick();
    check({name, "_state"}, 64'(bus.state), 64'(exp_st));
  endtask

  task automatic check_counters(input string name);
    check({name, "_stall_cycles"}, 64'(bus.stall_cycles), 64'(exp_stall));
    check({name, "_flush_count"},  64'(bus.flush_count),  64'(exp_flush));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = 0;
    exp_flush = 0;

    //               name        rs1 rs2 op      rd  ld redir req rdy  outs       st
    add("idle",       5'd0, 5'd0, OP_I,   5'd0, 0, 0, 0, 1, 6'b000000, 2'd0);
    add("lu_rs1_add", 5'd5, 5'd1, OP_R,   5'd5, 1, 0, 0, 1, 6'b110001, 2'd1);
    add("lu_rs2_add", 5'd2, 5'd5, OP_R,   5'd5, 1, 0, 0, 1, 6'b110001, 2'd1);
    add("rs2_itype",  5'd1, 5'd5, OP_I,   5'd5, 1, 0, 0, 1, 6'b000000, 2'd0);
    add("load_x0",    5'd0, 5'd0, OP_R,   5'd0, 1, 0, 0, 1, 6'b000000, 2'd0);
    add("lui_rs1",    5'd7, 5'd0, OP_LUI, 5'd7, 1, 0, 0, 1, 6'b000000, 2'd0);
    add("auipc_rs1",  5'd7, 5'd0, OP_AUI, 5'd7, 1, 0, 0, 1, 6'b000000, 2'd0);
    add("jal_rs1",    5'd7, 5'd7, OP_JAL, 5'd7, 1, 0, 0, 1, 6'b000000, 2'd0);
    add("no_load",    5'd5, 5'd5, OP_R,   5'd5, 0, 0, 0, 1, 6'b000000, 2'd0);
    add("lu_store",   5'd1, 5'd9, OP_ST,  5'd9, 1, 0, 0, 1, 6'b110001, 2'd1);
    add("lu_branch",  5'd9, 5'd3, OP_BR,  5'd9, 1, 0, 0, 1, 6'b110001, 2'd1);
    add("lu_jalr",    5'd4, 5'd0, OP_JLR, 5'd4, 1, 0, 0, 1, 6'b110001, 2'd1);
    add("lu_redir",   5'd5, 5'd1, OP_R,   5'd5, 1, 1, 0, 1, 6'b000011, 2'd0);
    add("redir",      5'd0, 5'd0, OP_I,   5'd0, 0, 1, 0, 1, 6'b000011, 2'd0);
    add("memwait",    5'd0, 5'd0, OP_I,   5'd0, 0, 0, 1, 0, 6'b111100, 2'd2);
    add("memw_all",   5'd5, 5'd1, OP_R,   5'd5, 1, 1, 1, 0, 6'b111100, 2'd2);
    add("mem_ready",  5'd0, 5'd0, OP_I,   5'd0, 0, 0, 1, 1, 6'b000000, 2'd0);

    // Reset state, with a memory wait presented on the inputs.
    rst_n = 1'b0;
    drive(5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #12;
    check("rst_outs",  64'(outs()), 64'd0);
    check("rst_state", 64'(bus.state), 64'd0);
    check("rst_err",   64'(bus.mem_timeout_err), 64'd0);
    check_counters("rst");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table vectors, each from RUN, followed by one idle cycle back to RUN.
    foreach (tbl[i]) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].op, tbl[i].rd, tbl[i].ld,
            tbl[i].redir, tbl[i].req, tbl[i].rdy);
      cycle(tbl[i].name, tbl[i].exp_o, tbl[i].exp_st);
      idle();
      cycle({tbl[i].name, "_recover"}, 6'b000000, 2'd0);
    end
    check_counters("table");

    // Bubble lasts one cycle and ignores a still-present hazard.
    drive(5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("bubble_enter", 6'b110001, 2'd1);
    cycle("bubble_noredetect", 6'b000000, 2'd0);
    // Memory wait during the bubble takes precedence.
    cycle("bubble_enter2", 6'b110001, 2'd1);
    drive(5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle("bubble_memwait", 6'b111100, 2'd2);
    idle();
    cycle("bubble_mem_done", 6'b000000, 2'd0);
    check_counters("bubble");

    // Three-cycle memory wait.
    drive(5'd0, 5'd0, OP_I, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) cycle($sformatf("mw3_c%0d", k), 6'b111100, 2'd2);
    drive(5'd0, 5'd0, OP_I, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("mw3_ready", 6'b000000, 2'd0);
    check_counters("mw3");
    check("mw3_err", 64'(bus.mem_timeout_err), 64'd0);

    // Six-cycle wait with MEM_TIMEOUT=4: error visible from cycle 5, sticky.
    drive(5'd0, 5'd0, OP_I, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      #3;
      check($sformatf("to_err_c%0d", k), 64'(bus.mem_timeout_err), 64'(k >= 5));
      check($sformatf("to_outs_c%0d", k), 64'(outs()), 64'(6'b111100));
      exp_stall++;
      tick();
    end
    idle();
    cycle("to_ready", 6'b000000, 2'd0);
    check("to_err_sticky", 64'(bus.mem_timeout_err), 64'd1);
    check_counters("to");

    // Reset asserted mid MEM_WAIT drops everything immediately.
    drive(5'd0, 5'd0, OP_I, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("rw_enter", 6'b111100, 2'd2);
    #1;
    rst_n = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    check("rw_outs",  64'(outs()), 64'd0);
    check("rw_state", 64'(bus.state), 64'd0);
    check("rw_err",   64'(bus.mem_timeout_err), 64'd0);
    check_counters("rw");
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rw_state_after", 64'(bus.state), 64'd0);
    drive(5'd5, 5'd1, OP_R, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle("rw_lu", 6'b110001, 2'd1);
    check_counters("rw_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the number of consecutive data-memory wait cycles after which the timeout error is raised.
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning the width of the performance counters.
REQ-003 SHALL have port clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port rs1_addr_id / rs2_addr_id  input  5 each  source register addresses of the instruction in ID.
REQ-006 SHALL have port opcode_id  input  7  opcode of the instruction in ID.
REQ-007 SHALL have port rd_addr_ex  input  5  destination register of the instruction in EX.
REQ-008 SHALL have port ctrl_mem_read_ex  input  1  the instruction in EX is a load.
REQ-009 SHALL have port redirect_ex  input  1  a taken branch or jump resolved in EX.
REQ-010 SHALL have port dmem_req_mem / dmem_ready  input  1 each  data-memory request issued in MEM / memory response ready.
REQ-011 SHALL have ports pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  output  1 each  hold the corresponding pipeline register.
REQ-012 SHALL have ports if_id_flush, id_ex_flush  output  1 each  insert a bubble into the corresponding pipeline register.
REQ-013 SHALL have port mem_timeout_err  output  1  sticky memory-timeout flag.
REQ-014 SHALL have ports stall_cycles, flush_count  output  CNT_WIDTH each  performance counters.
REQ-015 SHALL have port state  output  2  current FSM state.

Function
REQ-016 SHALL implement states RUN=0, LOAD_BUBBLE=1, MEM_WAIT=2; encoding 3 SHALL return to RUN on the next edge.
REQ-017 SHALL detect a load-use hazard when all of the following hold:
- ctrl_mem_read_ex=1 and rd_addr_ex!=0;
- either rs1_addr_id==rd_addr_ex and opcode_id is not LUI (0110111), AUIPC (0010111) or JAL (1101111);
- or rs2_addr_id==rd_addr_ex and opcode_id is R-type (0110011), STORE (0100011) or BRANCH (1100011).
REQ-018 SHALL detect a memory wait when dmem_req_mem=1 and dmem_ready=0.
REQ-019 SHALL apply this priority in RUN: memory wait > redirect > load-use.
REQ-020 On a memory wait, SHALL assert all four stall outputs combinationally in the same cycle, deassert both flush outputs, and enter MEM_WAIT.
REQ-021 In MEM_WAIT, SHALL keep all stalls asserted while dmem_ready=0, and return to RUN on the edge where dmem_ready=1 with zero stalls in that cycle.
REQ-022 On redirect_ex=1 (no memory wait), SHALL assert if_id_flush and id_ex_flush for that cycle only, assert no stalls, and remain in RUN; any coincident load-use hazard SHALL be ignored.
REQ-023 On a load-use hazard (no memory wait or redirect), SHALL assert pc_stall, if_id_stall and id_ex_flush for that cycle and enter LOAD_BUBBLE.
REQ-024 LOAD_BUBBLE SHALL last exactly one cycle with no hazard re-detection, then return to RUN; a memory wait in LOAD_BUBBLE SHALL take MEM_WAIT behaviour (REQ-020) instead.
REQ-025 SHALL keep a wait counter that increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
REQ-026 When the wait counter reaches MEM_TIMEOUT, SHALL set mem_timeout_err, which stays set until reset; stalls SHALL continue.
REQ-027 stall_cycles SHALL increment in every cycle where pc_stall=1, saturating at all-ones.
REQ-028 flush_count SHALL increment in every cycle where id_ex_flush=1, saturating at all-ones.
REQ-029 All outputs SHALL be a combinational function of the registered state and the current inputs; there SHALL be no combinational path from one output to another.

Reset
REQ-030 While rst_n=0, SHALL hold state=RUN, wait counter=0, mem_timeout_err=0, stall_cycles=0, flush_count=0, and all stall and flush outputs=0.
REQ-031 Reset mid-stall SHALL drop all stalls immediately (asynchronously) and discard any pending LOAD_BUBBLE or MEM_WAIT.

Verification
REQ-032 Load x5 in EX, add x6,x5,x1 in ID -> one cycle of pc_stall=if_id_stall=id_ex_flush=1, then state=RUN, stall_cycles=1, flush_count=1.
REQ-033 Load x0 in EX with rs1_id=0, and separately lui with rs1 field=rd_ex=7 -> no stall in either case.
REQ-034 Load-use hazard together with redirect_ex=1 -> flushes only, no stall, state stays RUN, flush_count+1.
REQ-035 dmem_req_mem=1 held with dmem_ready=0 for 3 cycles -> all stalls high 3 cycles, state=2; ready=1 -> RUN next cycle, stall_cycles=3.
REQ-036 MEM_TIMEOUT=4 with ready held low for 6 cycles -> mem_timeout_err=1 from the 5th cycle, still set after ready; cleared only by rst_n=0.
REQ-037 rst_n pulsed low during MEM_WAIT -> stalls drop immediately, state=0, counters=0.
